exec_forward_unit: RTL and testbench
====================================

# exec_forward_unit
Execute-stage cluster of the 5-stage MIPS pipeline: resolves ID-stage operand forwarding and branches, performs the ALU operation for the instruction held in ID/EX, and registers the results into the EX/MEM pipeline register. It sits between the ID/EX register (upstream) and the MEM/WB register (downstream).
## Interface
- Parameters: none
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  32  PC of instruction in decode
- rdata1, rdata2  in  32 each  register-file rs/rt values for the decode instruction
- imm  in  32  sign-extended decode immediate (branch offset)
- npc_op  in  3  decode branch kind
- stall  in  1  load-use stall request
- rs_hazard, rt_hazard  in  3 each  {ex_reg, mem_mem, mem_reg} hit flags per operand, already gated for $0
- ram_out  in  32  data-RAM read data, valid during MEM
- id_pc, id_rdata1, id_rdata2, id_imm  in  32 each  ID/EX registered PC, operands, immediate
- id_alu_op  in  5  ALU operation
- id_rs_sel, id_rt_sel  in  2 each  ALU operand A/B selects
- id_rf_wsel  in  3  write-back source select
- id_rd  in  5  destination register
- id_rf_nwe, id_is_ram  in  1 each  write-enable, memory-access flag
- out_rdata1, out_rdata2  out  32 each  forwarded decode operands (to ID/EX)
- dest  out  32  branch/jump target
- jmp  out  1  redirect fetch to dest
- alu_out  out  32  combinational ALU result (also data address)
- rf_nwef  out  1  final EX write-enable
- ex_pc, ex_result  out  32 each  EX/MEM PC and write-back value
- ex_rd  out  5; ex_rf_nwe, ex_is_ram  out  1 each  EX/MEM destination and flags
## Operation
- EX value = id_rf_wsel mux: 0 alu_out, 1 alu_out (load; data comes later), 2 id_pc+8, 3 id_rdata1; other codes → alu_out.
- Forwarding per operand, priority: ex_reg → EX value; mem_mem → ram_out; mem_reg → ex_result; none → rdata. Bit order [2]=ex_reg,[1]=mem_mem,[0]=mem_reg.
- ALU A: id_rs_sel 0 id_rdata1, 1 id_imm, else 0. B: id_rt_sel 0 id_rdata2, 1 id_imm, else 0.
- id_alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL B<<A[4:0], 9 SRL, 10 SRA, 11 LUI B<<16, 12 MOVZ out=A, 13 MOVN out=A; others → 0. Add/sub wrap mod 2^32, no overflow trap.
- rf_nwef = id_rf_nwe, cleared for MOVZ when B≠0 and MOVN when B==0.
- npc_op (using forwarded out_rdata1=a, out_rdata2=b, signed): 0 none, 1 a==b, 2 a≠b, 3 a≥0, 4 a>0, 5 a≤0, 6 a<0, 7 register jump (always). J/JAL are resolved in fetch; never here.
- dest = if_pc+4+(imm<<2) for codes 1-6; out_rdata1 for 7; if_pc+4 for 0.
- jmp = condition true and stall==0.
## Timing
- Forwarding, ALU, branch, rf_nwef, dest, jmp: combinational, same cycle.
- EX/MEM: on rising clk captures id_pc, EX value, id_rd, rf_nwef, id_is_ram; 1-cycle latency; no enable or flush (bubbles arrive from ID/EX as rf_nwe=0).
- rst asserted (any time, mid-operation included): all ex_* outputs 0 immediately; held until release.
- stall does not freeze this block's register.
## Test plan
- ADD id_rdata1=5, id_rdata2=7, sels 0 -> alu_out=12; next edge ex_result=12, ex_rf_nwe=1.
- SRA A=imm 4, B=0x8000_0000 -> 0xF800_0000; SLT -1 vs 1 -> 1, SLTU -> 0.
- rs_hazard=3'b111, EX value 0xA, ram_out 0xB -> out_rdata1=0xA; 3'b011 -> 0xB; 3'b001 -> ex_result.
- BEQ if_pc=0x100, imm=4, a==b -> jmp=1, dest=0x114; same with stall=1 -> jmp=0.
- MOVZ B=3 -> rf_nwef=0; B=0 -> rf_nwef=1, result=A.
- rst pulse mid-stream -> ex_pc, ex_result, ex_rd, ex_rf_nwe, ex_is_ram all 0 asynchronously.

Source files
------------

// File: rtl/exec_forward_unit.sv
// exec_forward_unit
//   Execute-stage cluster of the 5-stage MIPS pipeline.
//   - Resolves operand forwarding for the instruction in decode (rs/rt).
//   - Evaluates branch / register-jump conditions and the fetch redirect target.
//   - Performs the ALU operation for the instruction held in ID/EX.
//   - Registers PC, write-back value, destination and flags into EX/MEM.
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   if_pc, rdata1, rdata2, imm     decode PC, register-file operands, branch offset
//   npc_op, stall                  decode branch kind, load-use stall
//   rs_hazard, rt_hazard           {ex_reg, mem_mem, mem_reg} forwarding hits
//   ram_out                        data-RAM read data (MEM stage)
//   id_*                           ID/EX pipeline register contents
//   out_rdata1, out_rdata2         forwarded decode operands
//   dest, jmp                      fetch redirect target and strobe
//   alu_out, rf_nwef               ALU result (data address), final write-enable
//   ex_pc, ex_result, ex_rd,
//   ex_rf_nwe, ex_is_ram           EX/MEM pipeline register outputs
module exec_forward_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] imm,
  input  logic [2:0]  npc_op,
  input  logic        stall,
  input  logic [2:0]  rs_hazard,
  input  logic [2:0]  rt_hazard,
  input  logic [31:0] ram_out,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rdata1,
  input  logic [31:0] id_rdata2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_alu_op,
  input  logic [1:0]  id_rs_sel,
  input  logic [1:0]  id_rt_sel,
  input  logic [2:0]  id_rf_wsel,
  input  logic [4:0]  id_rd,
  input  logic        id_rf_nwe,
  input  logic        id_is_ram,
  output logic [31:0] out_rdata1,
  output logic [31:0] out_rdata2,
  output logic [31:0] dest,
  output logic        jmp,
  output logic [31:0] alu_out,
  output logic        rf_nwef,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_result,
  output logic [4:0]  ex_rd,
  output logic        ex_rf_nwe,
  output logic        ex_is_ram
);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND  = 5'd2,  ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,  ALU_NOR  = 5'd5,  ALU_SLT  = 5'd6,  ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA  = 5'd10, ALU_LUI  = 5'd11,
    ALU_MOVZ = 5'd12, ALU_MOVN = 5'd13
  } alu_op_e;

  typedef enum logic [2:0] {
    NPC_NONE = 3'd0, NPC_EQ  = 3'd1, NPC_NE  = 3'd2, NPC_GEZ = 3'd3,
    NPC_GTZ  = 3'd4, NPC_LEZ = 3'd5, NPC_LTZ = 3'd6, NPC_JR  = 3'd7
  } npc_op_e;

  logic [31:0] a_op, b_op;
  logic [31:0] ex_val;
  logic        cond;
  logic [31:0] pc_plus4;

  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_result_q, ex_result_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_rf_nwe_q, ex_rf_nwe_d;
  logic        ex_is_ram_q, ex_is_ram_d;

  // ALU operand selection
  always_comb begin
    case (id_rs_sel)
      2'd0:    a_op = id_rdata1;
      2'd1:    a_op = id_imm;
      default: a_op = '0;
    endcase
    case (id_rt_sel)
      2'd0:    b_op = id_rdata2;
      2'd1:    b_op = id_imm;
      default: b_op = '0;
    endcase
  end

  // ALU and conditional-move write-enable suppression
  always_comb begin
    alu_out = '0;
    rf_nwef = id_rf_nwe;
    case (id_alu_op)
      ALU_ADD:  alu_out = a_op + b_op;
      ALU_SUB:  alu_out = a_op - b_op;
      ALU_AND:  alu_out = a_op & b_op;
      ALU_OR:   alu_out = a_op | b_op;
      ALU_XOR:  alu_out = a_op ^ b_op;
      ALU_NOR:  alu_out = ~(a_op | b_op);
      ALU_SLT:  alu_out = {31'd0, $signed(a_op) < $signed(b_op)};
      ALU_SLTU: alu_out = {31'd0, a_op < b_op};
      ALU_SLL:  alu_out = b_op << a_op[4:0];
      ALU_SRL:  alu_out = b_op >> a_op[4:0];
      ALU_SRA:  alu_out = $unsigned($signed(b_op) >>> a_op[4:0]);
      ALU_LUI:  alu_out = b_op << 16;
      ALU_MOVZ: begin
        alu_out = a_op;
        if (b_op != '0) rf_nwef = 1'b0;
      end
      ALU_MOVN: begin
        alu_out = a_op;
        if (b_op == '0) rf_nwef = 1'b0;
      end
      default:  alu_out = '0;
    endcase
  end

  // Write-back value produced by the instruction in EX (loads fill in later)
  always_comb begin
    case (id_rf_wsel)
      3'd2:    ex_val = id_pc + 32'd8;
      3'd3:    ex_val = id_rdata1;
      default: ex_val = alu_out;
    endcase
  end

  // Forwarding: youngest producer wins (EX, then MEM load data, then MEM result)
  always_comb begin
    if (rs_hazard[2])      out_rdata1 = ex_val;
    else if (rs_hazard[1]) out_rdata1 = ram_out;
    else if (rs_hazard[0]) out_rdata1 = ex_result_q;
    else                   out_rdata1 = rdata1;
    if (rt_hazard[2])      out_rdata2 = ex_val;
    else if (rt_hazard[1]) out_rdata2 = ram_out;
    else if (rt_hazard[0]) out_rdata2 = ex_result_q;
    else                   out_rdata2 = rdata2;
  end

  // Branch resolution on forwarded operands
  assign pc_plus4 = if_pc + 32'd4;

  always_comb begin
    cond = 1'b0;
    dest = pc_plus4 + (imm << 2);
    case (npc_op)
      NPC_EQ:  cond = (out_rdata1 == out_rdata2);
      NPC_NE:  cond = (out_rdata1 != out_rdata2);
      NPC_GEZ: cond = ~out_rdata1[31];
      NPC_GTZ: cond = ~out_rdata1[31] && (out_rdata1 != '0);
      NPC_LEZ: cond = out_rdata1[31] || (out_rdata1 == '0);
      NPC_LTZ: cond = out_rdata1[31];
      NPC_JR: begin
        cond = 1'b1;
        dest = out_rdata1;
      end
      default: dest = pc_plus4;
    endcase
  end

  assign jmp = cond & ~stall;

  // EX/MEM pipeline register
  always_comb begin
    ex_pc_d     = id_pc;
    ex_result_d = ex_val;
    ex_rd_d     = id_rd;
    ex_rf_nwe_d = rf_nwef;
    ex_is_ram_d = id_is_ram;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc_q     <= '0;
      ex_result_q <= '0;
      ex_rd_q     <= '0;
      ex_rf_nwe_q <= 1'b0;
      ex_is_ram_q <= 1'b0;
    end else begin
      ex_pc_q     <= ex_pc_d;
      ex_result_q <= ex_result_d;
      ex_rd_q     <= ex_rd_d;
      ex_rf_nwe_q <= ex_rf_nwe_d;
      ex_is_ram_q <= ex_is_ram_d;
    end
  end

  assign ex_pc     = ex_pc_q;
  assign ex_result = ex_result_q;
  assign ex_rd     = ex_rd_q;
  assign ex_rf_nwe = ex_rf_nwe_q;
  assign ex_is_ram = ex_is_ram_q;

endmodule

// File: tb/tb_exec_forward_unit.sv
module tb_exec_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, rdata1, rdata2, imm;
  logic [2:0]  npc_op;
  logic        stall;
  logic [2:0]  rs_hazard, rt_hazard;
  logic [31:0] ram_out;
  logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_alu_op;
  logic [1:0]  id_rs_sel, id_rt_sel;
  logic [2:0]  id_rf_wsel;
  logic [4:0]  id_rd;
  logic        id_rf_nwe, id_is_ram;
  logic [31:0] out_rdata1, out_rdata2, dest, alu_out;
  logic        jmp, rf_nwef;
  logic [31:0] ex_pc, ex_result;
  logic [4:0]  ex_rd;
  logic        ex_rf_nwe, ex_is_ram;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_forward_unit dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .rdata1(rdata1), .rdata2(rdata2),
    .imm(imm), .npc_op(npc_op), .stall(stall), .rs_hazard(rs_hazard),
    .rt_hazard(rt_hazard), .ram_out(ram_out), .id_pc(id_pc),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_rs_sel(id_rs_sel), .id_rt_sel(id_rt_sel),
    .id_rf_wsel(id_rf_wsel), .id_rd(id_rd), .id_rf_nwe(id_rf_nwe),
    .id_is_ram(id_is_ram), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .dest(dest), .jmp(jmp), .alu_out(alu_out), .rf_nwef(rf_nwef),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_rd(ex_rd),
    .ex_rf_nwe(ex_rf_nwe), .ex_is_ram(ex_is_ram)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0; rdata1 = '0; rdata2 = '0; imm = '0; npc_op = 3'd0; stall = 1'b0;
    rs_hazard = '0; rt_hazard = '0; ram_out = '0;
    id_pc = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_alu_op = 5'd0;
    id_rs_sel = 2'd0; id_rt_sel = 2'd0; id_rf_wsel = 3'd0; id_rd = '0;
    id_rf_nwe = 1'b0; id_is_ram = 1'b0;

    @(negedge clk);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_ex_result", ex_result, 32'h0);
    chk("rst_ex_rf_nwe", ex_rf_nwe, 1'b0);
    rst = 1'b0;

    id_pc = 32'h40; id_rdata1 = 32'd5; id_rdata2 = 32'd7; id_alu_op = 5'd0;
    id_rd = 5'd3; id_rf_nwe = 1'b1; id_is_ram = 1'b1;
    #1;
    chk("add_alu", alu_out, 32'd12);
    chk("add_nwef", rf_nwef, 1'b1);
    @(posedge clk); #1;
    chk("add_ex_result", ex_result, 32'd12);
    chk("add_ex_rf_nwe", ex_rf_nwe, 1'b1);
    chk("add_ex_rd", ex_rd, 5'd3);
    chk("add_ex_pc", ex_pc, 32'h40);
    chk("add_ex_is_ram", ex_is_ram, 1'b1);
    id_is_ram = 1'b0;

    @(negedge clk);
    id_rs_sel = 2'd1; id_imm = 32'd4; id_rdata2 = 32'h8000_0000; id_alu_op = 5'd10;
    #1 chk("sra", alu_out, 32'hF800_0000);
    id_alu_op = 5'd9;
    #1 chk("srl", alu_out, 32'h0800_0000);
    id_alu_op = 5'd11; id_rt_sel = 2'd1; id_imm = 32'h1234;
    #1 chk("lui", alu_out, 32'h1234_0000);
    id_alu_op = 5'd1; id_rs_sel = 2'd0; id_rt_sel = 2'd0;
    id_rdata1 = 32'd3; id_rdata2 = 32'd5;
    #1 chk("sub_wrap", alu_out, 32'hFFFF_FFFE);

    id_rdata1 = 32'hFFFF_FFFF; id_rdata2 = 32'd1; id_alu_op = 5'd6;
    #1 chk("slt", alu_out, 32'd1);
    id_alu_op = 5'd7;
    #1 chk("sltu", alu_out, 32'd0);
    id_alu_op = 5'd20;
    #1 chk("undef_op", alu_out, 32'd0);

    @(negedge clk);
    id_rf_wsel = 3'd2; id_pc = 32'h200;
    @(posedge clk); #1;
    chk("pc8_ex_result", ex_result, 32'h208);

    id_rf_wsel = 3'd3; id_rdata1 = 32'hA; ram_out = 32'hB;
    rdata1 = 32'h11; rdata2 = 32'h22;
    rs_hazard = 3'b111;
    #1 chk("fwd_ex", out_rdata1, 32'hA);
    rs_hazard = 3'b011;
    #1 chk("fwd_mem", out_rdata1, 32'hB);
    rs_hazard = 3'b001;
    #1 chk("fwd_reg", out_rdata1, 32'h208);
    rs_hazard = 3'b000; rt_hazard = 3'b100;
    #1 chk("fwd_rt_ex", out_rdata2, 32'hA);
    chk("fwd_none", out_rdata1, 32'h11);
    rt_hazard = 3'b000;

    @(negedge clk);
    if_pc = 32'h100; imm = 32'd4; rdata1 = 32'h55; rdata2 = 32'h55; npc_op = 3'd1;
    #1;
    chk("beq_jmp", jmp, 1'b1);
    chk("beq_dest", dest, 32'h114);
    stall = 1'b1;
    #1 chk("beq_stall", jmp, 1'b0);
    stall = 1'b0; npc_op = 3'd2;
    #1 chk("bne_not", jmp, 1'b0);
    npc_op = 3'd7;
    #1 chk("jr_dest", dest, 32'h55);
    chk("jr_jmp", jmp, 1'b1);
    npc_op = 3'd6; rdata1 = 32'h8000_0000;
    #1 chk("bltz", jmp, 1'b1);
    npc_op = 3'd4; rdata1 = 32'h0;
    #1 chk("bgtz_zero", jmp, 1'b0);
    npc_op = 3'd5;
    #1 chk("blez_zero", jmp, 1'b1);
    npc_op = 3'd0;
    #1 chk("none_dest", dest, 32'h104);
    chk("none_jmp", jmp, 1'b0);
    imm = 32'hFFFF_FFFF; npc_op = 3'd3;
    #1 chk("bgez_back", dest, 32'h100);

    @(negedge clk);
    id_rf_wsel = 3'd0; id_alu_op = 5'd12; id_rdata1 = 32'h77; id_rdata2 = 32'd3;
    id_rf_nwe = 1'b1;
    #1 chk("movz_b3_nwef", rf_nwef, 1'b0);
    id_rdata2 = 32'd0;
    #1 chk("movz_b0_nwef", rf_nwef, 1'b1);
    chk("movz_out", alu_out, 32'h77);
    id_alu_op = 5'd13;
    #1 chk("movn_b0_nwef", rf_nwef, 1'b0);
    @(posedge clk); #1;
    chk("movn_ex_rf_nwe", ex_rf_nwe, 1'b0);

    id_alu_op = 5'd0; id_rdata1 = 32'd1; id_rdata2 = 32'd2; id_rd = 5'd9;
    id_is_ram = 1'b1; id_pc = 32'h300;
    @(posedge clk); #1;
    chk("pre_rst_result", ex_result, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", ex_pc, 32'h0);
    chk("arst_result", ex_result, 32'h0);
    chk("arst_rd", ex_rd, 5'h0);
    chk("arst_nwe", ex_rf_nwe, 1'b0);
    chk("arst_ram", ex_is_ram, 1'b0);
    @(posedge clk); #1;
    chk("held_result", ex_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_result", ex_result, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
